// File: rtl/cv32e40p_tb_periph_pkg.sv
// Shared constants for the bench peripheral slave: default address map, timer offsets, status magics.
package cv32e40p_tb_periph_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] TIMER_BASE_DEF   = 32'h1500_0000;
  localparam logic [31:0] STATUS_ADDR_DEF  = 32'h2000_0000;
  localparam logic [31:0] EXIT_ADDR_DEF    = 32'h2000_0004;

  localparam logic [31:0] PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] FAIL_MAGIC = 32'd1;

  // Byte offsets of the timer registers from TIMER_BASE
  typedef enum logic [3:0] {
    TMR_MTIME    = 4'h0,
    TMR_MTIMECMP = 4'h4,
    TMR_IRQ_CLR  = 4'h8
  } timer_reg_e;

  // Registers are word-sized, so sub-word byte addresses select the same register
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/cv32e40p_tb_char_fifo.sv
// 8-bit synchronous FIFO for console bytes; head byte visible combinationally, push/pop take effect at the edge.
// Push is ignored when full and pop when empty; the caller is expected to stall writers on full.
module cv32e40p_tb_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full_o  = (count == CNT_FULL);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  // Gate the head so an empty FIFO never exposes stale or uninitialised storage
  assign data_o  = empty_o ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_tb_periph_bus.sv
// Bench OBI peripheral slave: console FIFO, test status/exit pulses, mtime/mtimecmp timer; gnt combinational, rvalid 1 cycle later.
// Console writes are stalled (gnt=0) while the FIFO is full; the char stream drains it with valid/ready.
module cv32e40p_tb_periph_bus
  import cv32e40p_tb_periph_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] TIMER_BASE   = TIMER_BASE_DEF,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF,
  parameter logic [31:0] EXIT_ADDR    = EXIT_ADDR_DEF,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        periph_hit_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_data_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timer_irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel_console, sel_mtime, sel_cmp, sel_clr, sel_status, sel_exit;
  logic          fifo_full, fifo_empty, push, wr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rd_mux, rdata_q, exit_val_q, mtime_q, mtimecmp_q;
  logic          rvalid_q, passed_q, failed_q, exit_vld_q, cmp_armed_q, irq_q;
  logic          unused_be;

  assign sel_console = word_match(data_addr_i, CONSOLE_ADDR);
  assign sel_mtime   = word_match(data_addr_i, TIMER_BASE + 32'(TMR_MTIME));
  assign sel_cmp     = word_match(data_addr_i, TIMER_BASE + 32'(TMR_MTIMECMP));
  assign sel_clr     = word_match(data_addr_i, TIMER_BASE + 32'(TMR_IRQ_CLR));
  assign sel_status  = word_match(data_addr_i, STATUS_ADDR);
  assign sel_exit    = word_match(data_addr_i, EXIT_ADDR);

  assign periph_hit_o = sel_console | sel_mtime | sel_cmp | sel_clr | sel_status | sel_exit;
  // A full FIFO blocks the grant even if a pop lands in the same cycle
  assign data_gnt_o   = data_req_i & periph_hit_o & ~(sel_console & data_we_i & fifo_full);
  assign wr           = data_gnt_o & data_we_i;
  assign push         = wr & sel_console & data_be_i[0];
  assign char_valid_o = ~fifo_empty;
  assign unused_be    = ^data_be_i[3:1];

  always_comb begin
    rd_mux = '0;
    if (sel_console)    rd_mux = 32'(fifo_count);
    else if (sel_mtime) rd_mux = mtime_q;
    else if (sel_cmp)   rd_mux = mtimecmp_q;
  end

  cv32e40p_tb_char_fifo #(.DEPTH(FIFO_DEPTH)) u_char_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (data_wdata_i[7:0]),
    .pop_i   (char_valid_o & char_ready_i),
    .data_o  (char_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      passed_q   <= 1'b0;
      failed_q   <= 1'b0;
      exit_vld_q <= 1'b0;
      exit_val_q <= '0;
    end else begin
      rvalid_q   <= data_gnt_o;
      if (data_gnt_o) rdata_q <= data_we_i ? 32'd0 : rd_mux;
      passed_q   <= wr & sel_status & (data_wdata_i == PASS_MAGIC);
      failed_q   <= wr & sel_status & (data_wdata_i == FAIL_MAGIC);
      exit_vld_q <= wr & sel_exit;
      if (wr & sel_exit) exit_val_q <= data_wdata_i;
    end
  end

  // The sticky irq compares the registered mtime; a clear write overrides a same-cycle match
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '0;
      cmp_armed_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q <= (wr & sel_mtime) ? data_wdata_i : mtime_q + 32'd1;
      if (wr & sel_cmp) mtimecmp_q <= data_wdata_i;
      if (wr & sel_clr) begin
        irq_q       <= 1'b0;
        cmp_armed_q <= 1'b0;
      end else begin
        if (cmp_armed_q && (mtime_q == mtimecmp_q)) irq_q <= 1'b1;
        if (wr & sel_cmp) cmp_armed_q <= 1'b1;
      end
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_vld_q;
  assign exit_value_o   = exit_val_q;
  assign timer_irq_o    = irq_q;

endmodule

// File: tb/tb_cv32e40p_tb_periph_bus.sv
// Bench for the peripheral slave: table vectors, directed corner sequences and randomized traffic vs a queue-based model.
module tb_cv32e40p_tb_periph_bus;

  localparam logic [31:0] A_CON   = 32'h1000_0000;
  localparam logic [31:0] A_MTIME = 32'h1500_0000;
  localparam logic [31:0] A_CMP   = 32'h1500_0004;
  localparam logic [31:0] A_CLR   = 32'h1500_0008;
  localparam logic [31:0] A_STAT  = 32'h2000_0000;
  localparam logic [31:0] A_EXIT  = 32'h2000_0004;
  localparam logic [31:0] PASS_V  = 32'd123456789;
  localparam int          DEPTH   = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, char_ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, hit, char_valid, passed, failed, exit_valid, irq;
  logic [31:0] rdata, exit_value;
  logic [7:0]  char_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cv32e40p_tb_periph_bus dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rdata), .periph_hit_o(hit),
    .char_valid_o(char_valid), .char_ready_i(char_ready), .char_data_o(char_data),
    .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value), .timer_irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, timer as plain arithmetic on the visible registers
  logic [7:0]  mq[$];
  logic [7:0]  popped[$];
  logic        m_rvalid, m_pass, m_fail, m_exv, m_armed, m_irq;
  logic [31:0] m_rdata, m_exval, m_mtime, m_cmp;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_rvalid = 0; m_pass = 0; m_fail = 0; m_exv = 0; m_armed = 0; m_irq = 0;
    m_rdata = 0; m_exval = 0; m_mtime = 0; m_cmp = 0;
  endtask

  always @(negedge clk) if (rst_n && char_valid && char_ready) popped.push_back(char_data);

  always @(negedge clk) begin : model_chk
    logic        m_hit, m_gnt, con, w;
    logic [31:0] rd;
    if (chk_en) begin
      con   = (addr == A_CON);
      m_hit = addr inside {A_CON, A_MTIME, A_CMP, A_CLR, A_STAT, A_EXIT};
      m_gnt = req && m_hit && !(con && we && mq.size() == DEPTH);
      check("hit", hit, m_hit);
      check("gnt", gnt, m_gnt);
      check("rvalid", rvalid, m_rvalid);
      if (m_rvalid) check("rdata", rdata, m_rdata);
      check("char_valid", char_valid, mq.size() != 0);
      if (mq.size() != 0) check("char_data", char_data, mq[0]);
      check("passed", passed, m_pass);
      check("failed", failed, m_fail);
      check("exit_valid", exit_valid, m_exv);
      check("exit_value", exit_value, m_exval);
      check("irq", irq, m_irq);
      // state the DUT will hold after the coming edge
      w  = m_gnt && we;
      rd = 0;
      if (con) rd = 32'(mq.size());
      else if (addr == A_MTIME) rd = m_mtime;
      else if (addr == A_CMP) rd = m_cmp;
      m_rvalid = m_gnt;
      if (m_gnt) m_rdata = we ? 32'd0 : rd;
      if (mq.size() != 0 && char_ready) void'(mq.pop_front());
      if (w && con && be[0]) mq.push_back(wdata[7:0]);
      m_pass = w && addr == A_STAT && wdata == PASS_V;
      m_fail = w && addr == A_STAT && wdata == 32'd1;
      m_exv  = w && addr == A_EXIT;
      if (m_exv) m_exval = wdata;
      if (w && addr == A_CLR) begin
        m_irq = 0; m_armed = 0;
      end else begin
        if (m_armed && m_mtime == m_cmp) m_irq = 1;
        if (w && addr == A_CMP) m_armed = 1;
      end
      if (w && addr == A_CMP) m_cmp = wdata;
      m_mtime = (w && addr == A_MTIME) ? wdata : m_mtime + 32'd1;
    end
  end

  // One OBI transfer: hold req until granted or budget expires; returns at the negedge of the response cycle
  task automatic bus_op(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                        input int budget, output bit granted, output logic [31:0] rd);
    @(posedge clk); #1;
    req = 1; addr = a; we = w; be = b; wdata = d;
    granted = 0;
    for (int i = 0; i < budget && !granted; i++) begin
      @(negedge clk);
      if (gnt) granted = 1;
      else if (i < budget - 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req = 0; addr = 0; we = 0; be = 0; wdata = 0;
    @(negedge clk);
    rd = rdata;
    if (granted) check("rvalid_after_gnt", rvalid, 1);
  endtask

  task automatic wr_ok(input string name, input logic [31:0] a, input logic [31:0] d);
    bit g; logic [31:0] r;
    bus_op(a, 1'b1, 4'hF, d, 4, g, r);
    check(name, g, 1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    char_ready = v;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic        exp_gnt;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit g;
    logic [31:0] r;
    logic [31:0] pick[9];

    tbl[0]  = '{A_CMP,   1, 32'hDEAD_BEEF, 1, 32'h0};
    tbl[1]  = '{A_CMP,   0, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[2]  = '{A_CON,   0, 32'h0,         1, 32'h0};
    tbl[3]  = '{A_CLR,   0, 32'h0,         1, 32'h0};
    tbl[4]  = '{A_STAT,  0, 32'h0,         1, 32'h0};
    tbl[5]  = '{A_EXIT,  0, 32'h0,         1, 32'h0};
    tbl[6]  = '{32'h0000_1000, 0, 32'h0,   0, 32'h0};
    tbl[7]  = '{32'h1000_0004, 1, 32'h41,  0, 32'h0};
    tbl[8]  = '{32'h1500_000C, 0, 32'h0,   0, 32'h0};
    tbl[9]  = '{32'h2000_0008, 1, 32'h5,   0, 32'h0};
    tbl[10] = '{A_CLR,   1, 32'h0,         1, 32'h0};
    tbl[11] = '{A_EXIT,  1, 32'hCAFE_0001, 1, 32'h0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);          check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);      check("rst_hit", hit, 0);
    check("rst_char_valid", char_valid, 0); check("rst_char_data", char_data, 0);
    check("rst_passed", passed, 0);    check("rst_failed", failed, 0);
    check("rst_exit_valid", exit_valid, 0); check("rst_exit_value", exit_value, 0);
    check("rst_irq", irq, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    chk_en = 1;

    // decode / read-back vectors
    foreach (tbl[i]) begin
      bus_op(tbl[i].a, tbl[i].w, 4'hF, tbl[i].d, 3, g, r);
      check($sformatf("tbl%0d_gnt", i), g, tbl[i].exp_gnt);
      if (tbl[i].exp_gnt) check($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
    end

    // two console bytes drained in order, count reads back zero
    set_ready(1);
    popped.delete();
    wr_ok("con_a_gnt", A_CON, 32'h41);
    check("con_a_data", char_data, 8'h41);
    wr_ok("con_b_gnt", A_CON, 32'h42);
    check("con_b_data", char_data, 8'h42);
    bus_op(A_CON, 1'b0, 4'hF, 0, 4, g, r);
    check("con_count_drained", r, 0);
    check("con_stream_len", popped.size(), 2);
    if (popped.size() == 2) begin
      check("con_stream0", popped[0], 8'h41);
      check("con_stream1", popped[1], 8'h42);
    end

    // FIFO full: 17th write stalls until a pop, and not in the pop cycle itself
    set_ready(0);
    popped.delete();
    for (int i = 0; i < DEPTH; i++) wr_ok($sformatf("fill%0d_gnt", i), A_CON, 32'h60 + i);
    bus_op(A_CON, 1'b0, 4'hF, 0, 4, g, r);
    check("full_count", r, DEPTH);
    @(posedge clk); #1;
    req = 1; addr = A_CON; we = 1; be = 4'hF; wdata = 32'h70;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("full_stall", gnt, 0);
      @(posedge clk); #1;
    end
    char_ready = 1;
    @(negedge clk); check("full_stall_pop_cycle", gnt, 0);
    @(posedge clk); #1;
    char_ready = 0;
    @(negedge clk); check("full_gnt_after_pop", gnt, 1);
    @(posedge clk); #1;
    req = 0; addr = 0; we = 0; be = 0; wdata = 0;
    set_ready(1);
    repeat (24) @(posedge clk);
    check("full_stream_len", popped.size(), DEPTH + 1);
    for (int i = 0; i < popped.size() && i <= DEPTH; i++)
      check($sformatf("full_stream%0d", i), popped[i], 8'h60 + i);

    // status pulses
    wr_ok("pass_gnt", A_STAT, PASS_V);
    check("pass_pulse", passed, 1); check("pass_no_fail", failed, 0);
    @(negedge clk); check("pass_one_cycle", passed, 0);
    wr_ok("fail_gnt", A_STAT, 32'd1);
    check("fail_pulse", failed, 1); check("fail_no_pass", passed, 0);
    @(negedge clk); check("fail_one_cycle", failed, 0);
    wr_ok("other_gnt", A_STAT, 32'd7);
    check("other_no_pass", passed, 0); check("other_no_fail", failed, 0);

    // exit
    wr_ok("exit_gnt", A_EXIT, 32'd5);
    check("exit_pulse", exit_valid, 1); check("exit_val", exit_value, 5);
    @(negedge clk); check("exit_one_cycle", exit_valid, 0);
    repeat (5) @(negedge clk);
    check("exit_val_held", exit_value, 5);

    // timer wrap and compare irq
    wr_ok("cmp_gnt", A_CMP, 32'h1);
    wr_ok("mtime_gnt", A_MTIME, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("irq_low%0d", k), irq, 0);
      @(negedge clk);
    end
    check("irq_rise", irq, 1);
    wr_ok("clr_gnt", A_CLR, 32'h0);
    check("irq_cleared", irq, 0);
    repeat (3) @(negedge clk);
    check("irq_stays_low", irq, 0);

    // randomized traffic against the model
    pick = '{A_CON, A_CON, A_MTIME, A_CMP, A_CLR, A_STAT, A_EXIT, 32'h0000_0100, 32'h1500_000C};
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req        = ($urandom_range(0, 3) != 0);
      addr       = pick[$urandom_range(0, 8)];
      we         = $urandom_range(0, 1);
      be         = 4'($urandom_range(0, 15));
      char_ready = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       wdata = $urandom;
        1:       wdata = PASS_V;
        2:       wdata = 32'd1;
        default: wdata = $urandom_range(0, 40);
      endcase
    end
    @(posedge clk); #1;
    req = 0; addr = 0; we = 0; be = 0; wdata = 0;

    // reset with 3 buffered bytes and a granted read in flight
    char_ready = 1;
    repeat (24) @(posedge clk);
    set_ready(0);
    for (int i = 0; i < 3; i++) wr_ok($sformatf("pre_rst_push%0d", i), A_CON, 32'h30 + i);
    check("pre_rst_char_valid", char_valid, 1);
    @(posedge clk); #1;
    chk_en = 0;
    req = 1; addr = A_MTIME; we = 0; be = 4'hF;
    @(negedge clk); check("pre_rst_gnt", gnt, 1);
    #1;
    rst_n = 0; req = 0; addr = 0;
    @(negedge clk);
    check("mid_rst_rvalid", rvalid, 0);     check("mid_rst_rdata", rdata, 0);
    check("mid_rst_char_valid", char_valid, 0); check("mid_rst_gnt", gnt, 0);
    check("mid_rst_passed", passed, 0);     check("mid_rst_failed", failed, 0);
    check("mid_rst_exit_valid", exit_valid, 0); check("mid_rst_exit_value", exit_value, 0);
    check("mid_rst_irq", irq, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    chk_en = 1;
    bus_op(A_CON, 1'b0, 4'hF, 0, 4, g, r);
    check("post_rst_count", r, 0);
    bus_op(A_MTIME, 1'b0, 4'hF, 0, 4, g, r);
    check("post_rst_mtime_gnt", g, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
